// File: rtl/vrf_pkg.sv
// Shared types and default parameters for the vector register file.
package vrf_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_PRELOAD = 2'd1,
    ST_READY   = 2'd2
  } vrf_state_t;

  localparam int VRF_LANES     = 8;
  localparam int VRF_LANE_W    = 16;
  localparam int VRF_NREGS     = 16;
  localparam int VRF_CONST_IDX = 13;
  localparam int VRF_CONST_VAL = 'hA;

endpackage

// File: rtl/vrf_lane_merge.sv
// Per-lane masked merge: lanes with mask set take new data, the rest keep old data.
module vrf_lane_merge #(
  parameter int LANES  = 8,
  parameter int LANE_W = 16
) (
  input  logic [LANES*LANE_W-1:0] old_i,
  input  logic [LANES*LANE_W-1:0] new_i,
  input  logic [LANES-1:0]        mask_i,
  output logic [LANES*LANE_W-1:0] result_o
);

  always_comb begin
    result_o = old_i;
    for (int i = 0; i < LANES; i++) begin
      if (mask_i[i]) result_o[i*LANE_W +: LANE_W] = new_i[i*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/vector_register_file.sv
// Multi-lane vector register file with clear/preload start-up sequence.
// Optional same-cycle write-to-read bypass enabled by macro VREGFILE_BYPASS_EN.
//
// state   | meaning
// CLEAR   | zero one register per cycle, clr_idx 0..NREGS-1
// PRELOAD | write CONST_VAL into register CONST_IDX
// READY   | accept masked lane writes
module vector_register_file
  import vrf_pkg::*;
#(
  parameter int LANES     = VRF_LANES,
  parameter int LANE_W    = VRF_LANE_W,
  parameter int NREGS     = VRF_NREGS,
  parameter int CONST_IDX = VRF_CONST_IDX,
  parameter logic [LANES*LANE_W-1:0] CONST_VAL = (LANES*LANE_W)'(VRF_CONST_VAL)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [LANES-1:0]           wmask,
  input  logic [$clog2(NREGS)-1:0]   wa,
  input  logic [LANES*LANE_W-1:0]    wd,
  input  logic [$clog2(NREGS)-1:0]   ra1,
  input  logic [$clog2(NREGS)-1:0]   ra2,
  output logic [LANES*LANE_W-1:0]    rd1,
  output logic [LANES*LANE_W-1:0]    rd2,
  output logic                       ready,
  output logic                       wr_drop
);

  localparam int VW = LANES * LANE_W;
  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] CONST_A = AW'(CONST_IDX);
  localparam logic [AW-1:0] LAST_A  = AW'(NREGS - 1);

  vrf_state_t      state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic            wr_drop_q, wr_drop_d;
  logic [VW-1:0]   regs_q [NREGS];

  logic            wa_ok, wr_accept;
  logic [VW-1:0]   wr_old, wr_merged;

  assign wa_ok     = 32'(wa) < NREGS;
  assign wr_accept = (state_q == ST_READY) && we && wa_ok;
  assign wr_old    = wa_ok ? regs_q[wa] : '0;

  vrf_lane_merge #(.LANES(LANES), .LANE_W(LANE_W)) u_merge (
    .old_i    (wr_old),
    .new_i    (wd),
    .mask_i   (wmask),
    .result_o (wr_merged)
  );

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_idx_q == LAST_A) state_d = ST_PRELOAD;
        else                     clr_idx_d = clr_idx_q + 1'b1;
      end
      ST_PRELOAD: state_d = ST_READY;
      default:    state_d = ST_READY;
    endcase
    // An all-zero mask is a no-op, never a rejected write.
    wr_drop_d = we && (|wmask) && !wr_accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Array contents are deliberately left out of reset; the clear sequence defines them.
  always_ff @(posedge clk) begin
    case (state_q)
      ST_CLEAR:   regs_q[clr_idx_q] <= '0;
      ST_PRELOAD: regs_q[CONST_A]   <= CONST_VAL;
      default:    if (wr_accept) regs_q[wa] <= wr_merged;
    endcase
  end

  always_comb begin
    rd1 = (32'(ra1) < NREGS) ? regs_q[ra1] : '0;
    rd2 = (32'(ra2) < NREGS) ? regs_q[ra2] : '0;
`ifdef VREGFILE_BYPASS_EN
    if (wr_accept && (ra1 == wa)) rd1 = wr_merged;
    if (wr_accept && (ra2 == wa)) rd2 = wr_merged;
`endif
  end

  assign ready   = (state_q == ST_READY);
  assign wr_drop = wr_drop_q;

endmodule

// File: doc/vector_register_file.md
VECTOR_REGISTER_FILE -- requirements
Module: vector_register_file

Interface
REQ-001 Parameter LANES, default 8, SHALL set the number of SIMD lanes per vector register.
REQ-002 Parameter LANE_W, default 16, SHALL set the width of each lane in bits.
REQ-003 Parameter NREGS, default 16, SHALL set the register count, which must be at least 2.
REQ-004 Parameter CONST_IDX, default 13, SHALL set the register index preloaded with CONST_VAL after the clear sequence.
REQ-005 Parameter CONST_VAL, default 'hA, SHALL set the VW-bit preload value, where VW = LANES*LANE_W and AW = $clog2(NREGS).
REQ-006 The port list SHALL be as follows:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- we  in  1  write request.
- wmask  in  LANES  per-lane write enable; bit i covers lane i.
- wa  in  AW  write address.
- wd  in  VW  write data; lane i is wd[i*LANE_W +: LANE_W].
- ra1, ra2  in  AW  read addresses.
- rd1, rd2  out  VW  read data.
- ready  out  1  high when the file accepts writes.
- wr_drop  out  1  one-cycle pulse when a write request is rejected.

Function
REQ-007 The block SHALL contain a 3-state FSM with states CLEAR, PRELOAD and READY.
REQ-008 In CLEAR, one register per cycle SHALL be zeroed, using index counter clr_idx from 0 to NREGS-1.
REQ-009 After NREGS-1 is zeroed, the FSM SHALL go to PRELOAD; the full clear takes NREGS cycles.
REQ-010 PRELOAD SHALL write CONST_VAL to register CONST_IDX in one cycle, then go to READY.
REQ-011 ready SHALL be 1 only in READY, and SHALL first rise NREGS+1 posedges after rst deasserts.
REQ-012 In READY, when we=1, each lane i with wmask[i]=1 SHALL be updated in register wa at posedge; lanes with wmask[i]=0 SHALL be unchanged.
REQ-013 A write with we=1 and wmask all zero SHALL change nothing and SHALL NOT assert wr_drop.
REQ-014 A write with we=1 outside READY SHALL be discarded, and wr_drop SHALL pulse high for exactly the following cycle.
REQ-015 A write in READY with wa >= NREGS (non-power-of-2 NREGS) SHALL be discarded with a wr_drop pulse.
REQ-016 Reads SHALL be combinational: rd1 = reg[ra1] and rd2 = reg[ra2].
REQ-017 A read with ra >= NREGS SHALL return 0.
REQ-018 The two read ports SHALL be independent, and identical addresses SHALL return identical data.
REQ-019 Register index 0 SHALL be writable; there is no hardwired zero register.

Reset
REQ-020 Asserting rst at any time, including mid-CLEAR or mid-write, SHALL immediately force the following: FSM=CLEAR, clr_idx=0, ready=0, wr_drop=0.
REQ-021 Register array contents SHALL NOT be reset asynchronously; they are defined only after the clear sequence completes.
REQ-022 rd1 and rd2 SHALL be don't-care while ready=0, except for registers already cleared.

Configuration
REQ-023 With macro VREGFILE_BYPASS_EN defined, a read in READY whose address equals wa while we=1 SHALL return, per lane, wd where wmask=1 and stored data where wmask=0, in the same cycle.
REQ-024 Without VREGFILE_BYPASS_EN, reads SHALL return stored data only; a write becomes visible the cycle after its posedge.
REQ-025 Bypass SHALL never apply to dropped writes.

Structure
REQ-026 Package vrf_pkg SHALL hold the FSM state enum (vrf_state_t) and the default parameter constants.
REQ-027 Sub-module vrf_lane_merge SHALL implement the masked lane merge (old, new, mask -> result), shared by the write path and the bypass path.

Verification
REQ-028 Release rst and count cycles; ready SHALL rise at cycle 17, and reading all 16 registers SHALL return 0 except r13 = 'hA.
REQ-029 Write r3 with wmask=8'h0F and wd all lanes = 16'hBEEF, starting from r3 = 0; read r3 SHALL return lanes 0-3 = BEEF and lanes 4-7 = 0.
REQ-030 Assert we=1 at cycle 5 after rst release; wr_drop SHALL be high at cycle 6 only, and the target register SHALL be 0 after READY.
REQ-031 With bypass, write r7=all 16'h1234 with ra1=7 in the same cycle; rd1 SHALL be 1234s immediately. Without bypass, rd1 SHALL be 1234s only on the next cycle.
REQ-032 Assert rst mid-CLEAR at clr_idx=6, then release; ready SHALL again take 17 cycles, and the array SHALL be fully zeroed except r13.
REQ-033 Set ra1=ra2=13 in READY; rd1 and rd2 SHALL both equal 'hA.
